// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode path.
// PS2_ARROW_KEYS_EN adds the E0-prefixed Left/Right arrow mapping.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_st_e;

  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;

  typedef struct packed {
    logic       hit;
    logic [7:0] hid;
  } key_map_t;

  function automatic key_map_t map_code(
    input logic       ext,
    input logic [7:0] code
  );
    key_map_t r;
    r = '{hit: 1'b0, hid: KEY_NONE};
    if (!ext) begin
      case (code)
        8'h1C:   r = '{hit: 1'b1, hid: KEY_A};
        8'h23:   r = '{hit: 1'b1, hid: KEY_D};
        8'h29:   r = '{hit: 1'b1, hid: KEY_SPACE};
        8'h5A:   r = '{hit: 1'b1, hid: KEY_ENTER};
        8'h76:   r = '{hit: 1'b1, hid: KEY_ESC};
        default: r = '{hit: 1'b0, hid: KEY_NONE};
      endcase
    end
`ifdef PS2_ARROW_KEYS_EN
    else begin
      case (code)
        8'h6B:   r = '{hit: 1'b1, hid: KEY_LEFT};
        8'h74:   r = '{hit: 1'b1, hid: KEY_RIGHT};
        default: r = '{hit: 1'b0, hid: KEY_NONE};
      endcase
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: synchroniser, clock filter, frame FSM and timeout.
// Emits one registered byte_valid pulse per good frame.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam longint unsigned TO_L =
    64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000;
  localparam int TW = $clog2(TO_L + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_L);
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] F_MAX = FW'(FILT_LEN - 1);

  logic [1:0]    ck_sync_q, dt_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe;
  logic          dat;

  frame_st_e     state_q;
  logic [7:0]    sh_q;
  logic [2:0]    bit_q;
  logic          par_q;
  logic [TW-1:0] to_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          err_q;

  assign dat = dt_sync_q[1];

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (ck_sync_q[1] != filt_q) begin
      if (fcnt_q == F_MAX) begin
        filt_d = ck_sync_q[1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign strobe = filt_q & ~filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2_clk};
      dt_sync_q <= {dt_sync_q[0], ps2_dat};
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q != IDLE && to_q == TO_MAX) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
        to_q    <= '0;
      end else begin
        if (state_q == IDLE || strobe) begin
          to_q <= '0;
        end else begin
          to_q <= to_q + 1'b1;
        end
        if (strobe) begin
          unique case (state_q)
            IDLE: begin
              if (!dat) begin
                state_q <= DATA;
                bit_q   <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
            DATA: begin
              sh_q  <= {dat, sh_q[7:1]};
              bit_q <= bit_q + 1'b1;
              if (bit_q == 3'd7) state_q <= PARITY;
            end
            PARITY: begin
              par_q   <= dat;
              state_q <= STOP;
            end
            STOP: begin
              // odd parity over data plus parity bit
              if (dat && (^{sh_q, par_q})) begin
                valid_q <= 1'b1;
                byte_q  <= sh_q;
              end else begin
                err_q <= 1'b1;
              end
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 set-2 to HID keycode converter holding the last pressed key.
// PS2_ARROW_KEYS_EN enables the E0 6B / E0 74 arrow keys.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] kc_q, kc_d;
  logic       ev_q, ev_d;
  key_map_t   m;

  ps2_rx_frame #(
    .CLK_HZ     (CLK_HZ),
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .ps2_clk    (PS2_CLK),
    .ps2_dat    (PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (frame_err)
  );

  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    kc_d  = kc_q;
    ev_d  = 1'b0;
    m     = map_code(ext_q, rx_byte);
    if (rx_valid) begin
      if (rx_byte == BRK_PREFIX) begin
        brk_d = 1'b1;
      end else if (rx_byte == EXT_PREFIX) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        // only releasing the held key clears the output
        if (m.hit && !brk_q && m.hid != kc_q) begin
          kc_d = m.hid;
          ev_d = 1'b1;
        end else if (m.hit && brk_q && m.hid == kc_q) begin
          kc_d = KEY_NONE;
          ev_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      kc_q  <= KEY_NONE;
      ev_q  <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      kc_q  <= kc_d;
      ev_q  <= ev_d;
    end
  end

  assign keycode   = kc_q;
  assign key_event = ev_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Scoreboard bench for ps2_keycode: directed PS/2 frames, queued
// expected key_event/frame_err pulses checked by a separate monitor.
module tb_ps2_keycode;

  localparam int HALF = 20;

  logic       Clk;
  logic       Reset_n;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  ps2_keycode #(
    .CLK_HZ     (1_000_000),
    .FILT_LEN   (8),
    .TIMEOUT_US (2000)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .keycode   (keycode),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] kc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, want);
    end
  endtask

  task automatic pop_chk(input logic is_err);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse got err=%b kc=%h required none",
               is_err, keycode);
    end else begin
      e = expq.pop_front();
      if (e.is_err !== is_err || keycode !== e.kc) begin
        errors++;
        $display("FAIL pulse got err=%b kc=%h required err=%b kc=%h",
                 is_err, keycode, e.is_err, e.kc);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (key_event) pop_chk(1'b0);
      if (frame_err) pop_chk(1'b1);
    end
  end

  task automatic exp_ev(input logic [7:0] kc);
    expq.push_back('{is_err: 1'b0, kc: kc});
  endtask

  task automatic exp_err(input logic [7:0] kc);
    expq.push_back('{is_err: 1'b1, kc: kc});
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DAT = f[i];
      repeat (HALF) @(posedge Clk);
      PS2_CLK = 1'b0;
      repeat (HALF) @(posedge Clk);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_bits(mk(b, 1'b0), 11);
    repeat (50) @(posedge Clk);
  endtask

  initial begin
    logic [10:0] ones;
    ones    = '1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    Reset_n = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("reset_keycode", int'(keycode), 0);
    chk("reset_key_event", int'(key_event), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    Reset_n = 1'b1;
    repeat (20) @(posedge Clk);

    exp_ev(8'h04);
    send(8'h1C);
    exp_ev(8'h00);
    send(8'hF0);
    send(8'h1C);

    exp_ev(8'h07);
    send(8'h23);
    send(8'h23);
    send(8'h23);
    send(8'hF0);
    send(8'h1C);
    #1;
    chk("held_d_after_a_break", int'(keycode), 8'h07);

    exp_ev(8'h00);
    send(8'hF0);
    send(8'h23);

    exp_err(8'h00);
    ps2_bits(mk(8'h29, 1'b1), 11);
    repeat (50) @(posedge Clk);
    exp_ev(8'h2C);
    send(8'h29);

    exp_err(8'h2C);
    ps2_bits(ones, 1);
    repeat (50) @(posedge Clk);

    exp_err(8'h2C);
    ps2_bits(mk(8'h5A, 1'b0), 5);
    repeat (2500) @(posedge Clk);
    exp_ev(8'h28);
    send(8'h5A);
    exp_ev(8'h00);
    send(8'hF0);
    send(8'h5A);

`ifdef PS2_ARROW_KEYS_EN
    exp_ev(8'h50);
    exp_ev(8'h00);
`endif
    send(8'hE0);
    send(8'h6B);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    send(8'hE0);
    send(8'h1C);
    #1;
    chk("ext_no_alias", int'(keycode), 0);

    exp_ev(8'h04);
    send(8'h1C);
    ps2_bits(mk(8'h23, 1'b0), 3);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_keycode", int'(keycode), 0);
    chk("async_reset_key_event", int'(key_event), 0);
    repeat (5) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (20) @(posedge Clk);
    exp_ev(8'h04);
    send(8'h1C);

    repeat (100) @(posedge Clk);
    chk("pending_expected", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
